// File: rtl/run_code_packer.sv
// Packs run codes and limited-Golomb run-interruption codes MSB-first into
// 32-bit words, buffered in a small FIFO with sticky overflow reporting.
module run_code_packer #(
    parameter int QBPP       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_out1,
    input  logic [31:0] codes_r,
    input  logic [5:0]  codes_r_len,
    input  logic        en_out2,
    input  logic [8:0]  EMErrval,
    input  logic [4:0]  k,
    input  logic [5:0]  glimit,
    input  logic        flush,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        flush_done,
    output logic        ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [8:0]  gol_q;
    logic [6:0]  gol_limit;
    logic [8:0]  em_minus1;
    logic [31:0] gol_code;
    logic [5:0]  gol_len;
    logic [31:0] run_mask;

    logic        s1_run_v_reg, s1_gol_v_reg, s1_flush_reg;
    logic [31:0] s1_run_code_reg, s1_gol_code_reg;
    logic [5:0]  s1_run_len_reg, s1_gol_len_reg;

    logic [31:0] acc_reg, acc_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic        flush_done_reg, ovf_reg;

    logic [6:0]  l1, l2, total, sh1, sh2;
    logic [31:0] run_bits, gol_bits;
    logic [95:0] wide;
    logic [1:0]  n_full, n_wr, n_acc;
    logic [31:0] wr_word [3];

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next, space;
    logic          pop, drop;

    assign gol_q     = EMErrval >> k;
    assign gol_limit = {1'b0, glimit} - 7'(QBPP) - 7'd1;
    assign em_minus1 = EMErrval - 9'd1;
    assign run_mask  = codes_r_len[5] ? 32'hFFFF_FFFF : ((32'd1 << codes_r_len[4:0]) - 32'd1);

    // Leading zeros of the unary part are implicit: the code is right-justified in gol_code.
    always_comb begin
        gol_code = '0;
        gol_len  = '0;
        if ({1'b0, gol_q} < {3'b000, gol_limit}) begin
            gol_code = (32'd1 << k) | ({23'd0, EMErrval} & ((32'd1 << k) - 32'd1));
            gol_len  = gol_q[5:0] + 6'd1 + {1'b0, k};
        end else begin
            gol_code = (32'd1 << QBPP) | ({23'd0, em_minus1} & ((32'd1 << QBPP) - 32'd1));
            gol_len  = glimit;
        end
    end

    assign l1       = s1_run_v_reg ? {1'b0, s1_run_len_reg} : 7'd0;
    assign l2       = s1_gol_v_reg ? {1'b0, s1_gol_len_reg} : 7'd0;
    assign run_bits = s1_run_v_reg ? s1_run_code_reg : 32'd0;
    assign gol_bits = s1_gol_v_reg ? s1_gol_code_reg : 32'd0;
    assign total    = {2'b00, cnt_reg} + l1 + l2;
    assign sh1      = 7'd96 - {2'b00, cnt_reg} - l1;
    assign sh2      = sh1 - l2;

    // Pending bits sit left-aligned at the top; new codes are OR-ed in just below them.
    assign wide = {acc_reg, 64'd0}
                | ({64'd0, run_bits} << sh1)
                | ({64'd0, gol_bits} << sh2);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_words
            assign wr_word[gi] = wide[95 - 32*gi -: 32];
        end
    endgenerate

    assign n_full = total[6:5];
    assign n_wr   = n_full + {1'b0, (s1_flush_reg && (total[4:0] != 5'd0))};
    assign acc_next = s1_flush_reg ? 32'd0 : wr_word[n_full];
    assign cnt_next = s1_flush_reg ? 5'd0 : total[4:0];

    assign pop   = (count_reg != '0) && word_ready;
    assign space = CW'(FIFO_DEPTH) - count_reg + {{(CW-1){1'b0}}, pop};

    // Writes beyond the free space are dropped; earlier bits always win the space.
    always_comb begin
        n_acc = n_wr;
        drop  = 1'b0;
        if (CW'(n_wr) > space) begin
            n_acc = space[1:0];
            drop  = 1'b1;
        end
        count_next = count_reg + CW'(n_acc) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_run_v_reg    <= 1'b0;
            s1_gol_v_reg    <= 1'b0;
            s1_flush_reg    <= 1'b0;
            s1_run_code_reg <= '0;
            s1_gol_code_reg <= '0;
            s1_run_len_reg  <= '0;
            s1_gol_len_reg  <= '0;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            flush_done_reg  <= 1'b0;
            ovf_reg         <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            s1_run_v_reg    <= en_out1;
            s1_gol_v_reg    <= en_out2;
            s1_flush_reg    <= flush;
            s1_run_code_reg <= codes_r & run_mask;
            s1_gol_code_reg <= gol_code;
            s1_run_len_reg  <= codes_r_len;
            s1_gol_len_reg  <= gol_len;
            acc_reg         <= acc_next;
            cnt_reg         <= cnt_next;
            flush_done_reg  <= s1_flush_reg;
            ovf_reg         <= ovf_reg | drop;
            wr_ptr_reg      <= wr_ptr_reg + AW'(n_acc);
            rd_ptr_reg      <= rd_ptr_reg + AW'(pop);
            count_reg       <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < n_acc) begin
                mem[wr_ptr_reg + AW'(i)] <= wr_word[i];
            end
        end
    end

    assign word_valid = (count_reg != '0);
    assign word_out   = word_valid ? mem[rd_ptr_reg] : 32'd0;
    assign flush_done = flush_done_reg;
    assign ovf        = ovf_reg;

endmodule

// File: tb/tb_run_code_packer.sv
// Scenario bench for run_code_packer: directed vectors plus a randomized
// stream checked against a bit-queue reference model.
module tb_run_code_packer;
    localparam int QBPP  = 8;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en_out1 = 1'b0;
    logic [31:0] codes_r = '0;
    logic [5:0]  codes_r_len = '0;
    logic        en_out2 = 1'b0;
    logic [8:0]  EMErrval = '0;
    logic [4:0]  k = '0;
    logic [5:0]  glimit = 6'd32;
    logic        flush = 1'b0;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        flush_done;
    logic        ovf;

    int tests_run = 0;
    int tests_failed = 0;

    bit          mbits[$];
    logic [31:0] exp_words[$];
    logic [31:0] got[$];

    always #5 clk = ~clk;

    run_code_packer #(.QBPP(QBPP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .en_out1(en_out1), .codes_r(codes_r), .codes_r_len(codes_r_len),
        .en_out2(en_out2), .EMErrval(EMErrval), .k(k), .glimit(glimit),
        .flush(flush), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .flush_done(flush_done), .ovf(ovf)
    );

    // Capture every accepted word (handshake seen mid-cycle, pop at next edge).
    always @(negedge clk) begin
        if (reset && word_valid && word_ready) got.push_back(word_out);
    end

    // Reference model: a plain bit queue, cut into 32-bit words MSB-first.
    function automatic void model_push(input logic [31:0] v, input int len);
        logic [31:0] w;
        for (int i = len - 1; i >= 0; i--) begin
            mbits.push_back(v[i]);
            if (mbits.size() == 32) begin
                w = '0;
                for (int j = 0; j < 32; j++) w = {w[30:0], mbits.pop_front()};
                exp_words.push_back(w);
            end
        end
    endfunction

    function automatic void model_golomb(input int em, input int kk, input int gl);
        int limit = gl - QBPP - 1;
        int q = em >> kk;
        if (q < limit) begin
            model_push(32'd0, q);
            model_push(32'd1, 1);
            model_push(32'(em), kk);
        end else begin
            model_push(32'd0, limit);
            model_push(32'd1, 1);
            model_push(32'((em - 1) & ((1 << QBPP) - 1)), QBPP);
        end
    endfunction

    function automatic void model_flush();
        if (mbits.size() > 0) model_push(32'd0, 32 - mbits.size());
    endfunction

    function automatic void model_clear();
        mbits.delete();
        exp_words.delete();
        got.delete();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; returns just after the sampling edge.
    task automatic drive(input logic e1, input logic [31:0] code, input int len,
                         input logic e2, input int em, input int kk, input int gl,
                         input logic fl);
        en_out1 = e1; codes_r = code; codes_r_len = 6'(len);
        en_out2 = e2; EMErrval = 9'(em); k = 5'(kk); glimit = 6'(gl);
        flush = fl;
        if (e1) model_push(code, len);
        if (e2) model_golomb(em, kk, gl);
        if (fl) model_flush();
        step();
        en_out1 = 1'b0; en_out2 = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (word_out !== 32'd0) begin tests_failed++; $display("FAIL reset_word_out: got %h expected 00000000", word_out); end
        tests_run++;
        if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
        tests_run++;
        if (flush_done !== 1'b0) begin tests_failed++; $display("FAIL reset_flush_done: got %b expected 0", flush_done); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        reset = 1'b1;
        step();
        $display("[TB] reset checked");
    endtask

    task automatic test_golomb_flush();
        model_clear();
        word_ready = 1'b0;
        drive(1'b0, 32'd0, 0, 1'b1, 5, 1, 32, 1'b0);
        drive(1'b0, 32'd0, 0, 1'b0, 0, 0, 32, 1'b1);
        tests_run++;
        if (flush_done !== 1'b0) begin tests_failed++; $display("FAIL golomb_flush_early: got %b expected 0", flush_done); end
        step();
        tests_run++;
        if (flush_done !== 1'b1) begin tests_failed++; $display("FAIL golomb_flush_done: got %b expected 1", flush_done); end
        tests_run++;
        if (word_valid !== 1'b1 || word_out !== 32'h3000_0000) begin
            tests_failed++; $display("FAIL golomb_word: got valid=%b %h expected valid=1 30000000", word_valid, word_out);
        end
        step();
        tests_run++;
        if (flush_done !== 1'b0) begin tests_failed++; $display("FAIL golomb_flush_pulse: got %b expected 0", flush_done); end
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        tests_run++;
        if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL golomb_pop: got valid=%b expected 0", word_valid); end
        $display("[TB] golomb 5/k1 word %h", 32'h3000_0000);
    endtask

    task automatic test_escape();
        model_clear();
        drive(1'b0, 32'd0, 0, 1'b1, 300, 0, 32, 1'b0);
        tests_run++;
        if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL escape_early: got valid=%b expected 0", word_valid); end
        step();
        tests_run++;
        if (word_valid !== 1'b1 || word_out !== 32'h0000_012B) begin
            tests_failed++; $display("FAIL escape_word: got valid=%b %h expected valid=1 0000012b", word_valid, word_out);
        end
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        tests_run++;
        if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL escape_pop: got valid=%b expected 0", word_valid); end
        $display("[TB] escape 300/k0 word %h", 32'h0000_012B);
    endtask

    task automatic test_same_cycle();
        model_clear();
        drive(1'b1, 32'hF, 4, 1'b1, 5, 1, 32, 1'b0);
        drive(1'b0, 32'd0, 0, 1'b0, 0, 0, 32, 1'b1);
        step();
        tests_run++;
        if (word_valid !== 1'b1 || word_out !== 32'hF300_0000) begin
            tests_failed++; $display("FAIL same_cycle_word: got valid=%b %h expected valid=1 f3000000", word_valid, word_out);
        end
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        tests_run++;
        if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL same_cycle_single: got valid=%b expected 0", word_valid); end
        $display("[TB] same-cycle run+golomb word %h", 32'hF300_0000);
    endtask

    task automatic test_two_words_flush();
        logic [31:0] c1, c2;
        logic [39:0] cat;
        model_clear();
        c1 = $urandom; c2 = $urandom;
        cat = {c1[19:0], c2[19:0]};
        word_ready = 1'b1;
        drive(1'b1, c1, 20, 1'b0, 0, 0, 32, 1'b0);
        drive(1'b1, c2, 20, 1'b0, 0, 0, 32, 1'b0);
        drive(1'b0, 32'd0, 0, 1'b0, 0, 0, 32, 1'b1);
        repeat (6) step();
        word_ready = 1'b0;
        tests_run++;
        if (got.size() != 2) begin
            tests_failed++; $display("FAIL two_words_count: got %0d expected 2", got.size());
        end else begin
            tests_run++;
            if (got[0] !== cat[39:8]) begin tests_failed++; $display("FAIL two_words_first: got %h expected %h", got[0], cat[39:8]); end
            tests_run++;
            if (got[1] !== {cat[7:0], 24'd0}) begin tests_failed++; $display("FAIL two_words_second: got %h expected %h", got[1], {cat[7:0], 24'd0}); end
        end
        $display("[TB] two 20-bit codes + flush, %0d words popped", got.size());
    endtask

    task automatic test_overflow();
        model_clear();
        word_ready = 1'b0;
        repeat (8) drive(1'b1, 32'hFFFF_FFFF, 32, 1'b0, 0, 0, 32, 1'b0);
        step();
        tests_run++;
        if (ovf !== 1'b0 || word_valid !== 1'b1) begin
            tests_failed++; $display("FAIL ovf_full_no_drop: got ovf=%b valid=%b expected ovf=0 valid=1", ovf, word_valid);
        end
        drive(1'b1, 32'hFFFF_FFFF, 32, 1'b0, 0, 0, 32, 1'b0);
        step();
        tests_run++;
        if (ovf !== 1'b1 || word_valid !== 1'b1) begin
            tests_failed++; $display("FAIL ovf_set: got ovf=%b valid=%b expected ovf=1 valid=1", ovf, word_valid);
        end
        word_ready = 1'b1;
        repeat (10) step();
        word_ready = 1'b0;
        tests_run++;
        if (got.size() != 8) begin tests_failed++; $display("FAIL ovf_word_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL ovf_word%0d: got %h expected ffffffff", i, got[i]); end
        end
        tests_run++;
        if (ovf !== 1'b1 || word_valid !== 1'b0) begin
            tests_failed++; $display("FAIL ovf_sticky: got ovf=%b valid=%b expected ovf=1 valid=0", ovf, word_valid);
        end
        $display("[TB] overflow: 9 words offered, %0d buffered", got.size());
    endtask

    task automatic test_mid_reset();
        model_clear();
        word_ready = 1'b0;
        repeat (3) drive(1'b1, $urandom, 32, 1'b0, 0, 0, 32, 1'b0);
        drive(1'b1, $urandom, 10, 1'b0, 0, 0, 32, 1'b0);
        repeat (2) step();
        tests_run++;
        if (word_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_pre: got valid=%b expected 1", word_valid); end
        reset = 1'b0;
        #1;
        tests_run++;
        if (word_valid !== 1'b0 || word_out !== 32'd0 || ovf !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset_clear: got valid=%b word=%h ovf=%b expected 0 00000000 0", word_valid, word_out, ovf);
        end
        step();
        reset = 1'b1;
        model_clear();
        drive(1'b0, 32'd0, 0, 1'b0, 0, 0, 32, 1'b1);
        step();
        tests_run++;
        if (flush_done !== 1'b1 || word_valid !== 1'b0) begin
            tests_failed++; $display("FAIL mid_reset_flush: got done=%b valid=%b expected done=1 valid=0", flush_done, word_valid);
        end
        repeat (3) step();
        tests_run++;
        if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_no_word: got valid=%b expected 0", word_valid); end
        $display("[TB] mid-operation reset discarded pending state");
    endtask

    task automatic test_random_stream();
        int waited;
        model_clear();
        for (int n = 0; n < 300; n++) begin
            word_ready = ($urandom_range(0, 7) != 0);
            drive(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 32),
                  1'($urandom_range(0, 1)), $urandom_range(0, 511),
                  $urandom_range(0, QBPP), $urandom_range(QBPP + 2, 32),
                  1'($urandom_range(0, 15) == 0));
        end
        word_ready = 1'b1;
        drive(1'b0, 32'd0, 0, 1'b0, 0, 0, 32, 1'b1);
        waited = 0;
        while (got.size() < exp_words.size() && waited < 100) begin
            step();
            waited++;
        end
        repeat (3) step();
        tests_run++;
        if (got.size() != exp_words.size()) begin
            tests_failed++; $display("FAIL random_count: got %0d words expected %0d", got.size(), exp_words.size());
        end
        for (int i = 0; i < got.size() && i < exp_words.size(); i++) begin
            tests_run++;
            if (got[i] !== exp_words[i]) begin
                tests_failed++; $display("FAIL random_word%0d: got %h expected %h", i, got[i], exp_words[i]);
            end
        end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL random_ovf: got %b expected 0", ovf); end
        $display("[TB] random stream: %0d words compared", got.size());
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_golomb_flush();
        test_escape();
        test_same_cycle();
        test_two_words_flush();
        test_overflow();
        test_mid_reset();
        test_random_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/run_code_packer.md
RUN_CODE_PACKER -- requirements
Module: run_code_packer

Interface
REQ-001 Parameter QBPP, default 8: bits per escaped mapped error value.
REQ-002 Parameter FIFO_DEPTH, default 8: number of 32-bit output words buffered; power of two.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; clears all state immediately.
REQ-005 en_out1  in  1  run-code valid, one-cycle strobe.
REQ-006 codes_r  in  32  run code, right-justified, LSB-aligned.
REQ-007 codes_r_len  in  6  run code length in bits, 0..32.
REQ-008 en_out2  in  1  run-interruption error valid, one-cycle strobe.
REQ-009 EMErrval  in  9  mapped run-interruption error value.
REQ-010 k  in  5  Golomb parameter, 0..QBPP.
REQ-011 glimit  in  6  code length limit, QBPP+2..32.
REQ-012 flush  in  1  one-cycle request: pad pending bits to a word boundary.
REQ-013 word_out  out  32  packed bitstream word, first bit at bit 31.
REQ-014 word_valid  out  1  word_out holds an unread word.
REQ-015 word_ready  in  1  consumer accepts word_out when word_valid && word_ready.
REQ-016 flush_done  out  1  one-cycle pulse; flush completed in the accumulator.
REQ-017 ovf  out  1  sticky: a word was produced while the FIFO was full.

Function
REQ-018 Stage 1 (edge E1 after sampling edge E0) SHALL register the limited Golomb code of EMErrval: q = EMErrval >> k; if q < glimit-QBPP-1, code = q zeros, a 1, then the k LSBs of EMErrval, length q+1+k; otherwise code = (glimit-QBPP-1) zeros, a 1, then the QBPP LSBs of (EMErrval-1), length glimit.
REQ-019 Stage 1 SHALL also register codes_r, codes_r_len, en_out1, en_out2 and flush unchanged, so both streams reach stage 2 aligned.
REQ-020 A stage-1 entry with en_out1 low, or with codes_r_len = 0, SHALL contribute no bits.
REQ-021 Stage 2 (edge E2) SHALL append to the bit accumulator, MSB-first: the run code first, then the Golomb code, when both are valid in the same cycle.
REQ-022 Arrival order across cycles SHALL be preserved.
REQ-023 The accumulator SHALL hold 0..31 pending bits between cycles.
REQ-024 The accumulator SHALL accept up to 64 new bits per cycle.
REQ-025 Each completed 32-bit word SHALL be written to the FIFO at E2, up to two words per cycle.
REQ-026 When two words complete in one cycle, the earlier bits SHALL form the first FIFO entry.
REQ-027 Flush (applied at stage 2, after that cycle's codes) with pending count P > 0 SHALL pad 32-P zero bits and write the resulting word.
REQ-028 Flush with P = 0 SHALL write no word.
REQ-029 In both flush cases, flush_done SHALL be high for the one cycle after E2 and the accumulator SHALL be empty.
REQ-030 Latency: a word completed at E2 SHALL make word_valid high after E2 if the FIFO was empty.
REQ-031 word_out/word_valid SHALL reflect the FIFO head; a pop SHALL occur on every cycle with word_valid && word_ready.
REQ-032 A pop and up to two writes in the same cycle SHALL all be honoured; occupancy changes by writes-pops.
REQ-033 A write that finds the FIFO full after that cycle's pop SHALL be dropped.
REQ-034 On a dropped write, ovf SHALL be set and held until reset.
REQ-035 On a dropped write, the remaining accumulator state SHALL stay consistent.
REQ-036 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-037 Upstream strobes SHALL NOT be back-pressured; the block always samples en_out1/en_out2/flush.

Reset
REQ-038 While reset is low: word_out=0, word_valid=0, flush_done=0, ovf=0.
REQ-039 While reset is low: stage registers cleared, accumulator count=0, FIFO empty.
REQ-040 Reset asserted mid-operation SHALL discard all pending bits and buffered words.
REQ-041 After reset, the first strobe SHALL be processed as from an empty state.

Verification
REQ-042 EMErrval=5, k=1, glimit=32, then flush -> word 0x30000000 (code 0011, length 4), flush_done one cycle after E2.
REQ-043 EMErrval=300, k=0, glimit=32 -> escape code length 32, word 0x0000012B, word_valid after E2 with no flush needed.
REQ-044 Same cycle: codes_r=0xF, codes_r_len=4, en_out1=1 and EMErrval=5, k=1, glimit=32, en_out2=1; then flush -> single word 0xF3000000.
REQ-045 en_out1 with codes_r=0xFFFFFFFF, len 32, for 9 consecutive cycles, word_ready=0 -> 8 words buffered, 9th dropped, ovf=1 until reset, word_valid stays 1.
REQ-046 Two 20-bit codes then flush, word_ready=1 -> first word written, 8 pending bits padded into a second word, two words popped in order.
REQ-047 Reset low for one cycle while 3 words are buffered and 10 bits pending -> word_valid=0 immediately; next flush yields flush_done with no word.
